// File: rtl/tdm_pkg.sv
// Shared types and constants for the 8-slot TDM receive path.
package tdm_pkg;

    localparam int unsigned NUM_SLOTS = 8;
    localparam int unsigned SLOT_W    = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tdm_state_e;

    typedef logic [SLOT_W-1:0] slot_t;

    // Slot after `slot`; the 3-bit width makes 7 wrap to 0.
    function automatic slot_t slot_next(slot_t slot);
        return slot + slot_t'(1);
    endfunction

    function automatic logic is_last_slot(slot_t slot);
        return slot == slot_t'(NUM_SLOTS - 1);
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping slot counter; clear beats load-to-1, which beats increment.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en_i,
    input  logic  load1_i,
    input  logic  clr_i,
    output slot_t slot_o
);

    slot_t slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clr_i) begin
            slot_d = '0;
        end else if (load1_i) begin
            slot_d = slot_t'(1);
        end else if (en_i) begin
            slot_d = slot_next(slot_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux8.sv
// Receive end of the 8-channel TDM link: per-slot shadow capture, atomic frame
// transfer to ch with a one-cycle frame_valid, and sync-based framing.
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH            = 1,
    parameter bit          SYNC_EVERY_FRAME = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           din,
    input  logic                       sync,
    input  logic                       en_bar,
    output logic [SLOT_W-1:0]          s,
    output logic [NUM_SLOTS*WIDTH-1:0] ch,
    output logic                       frame_valid,
    output logic                       locked,
    output logic                       sync_err
);

    tdm_state_e state_q, state_d;

    logic [WIDTH-1:0]           shadow_q [NUM_SLOTS];
    logic [WIDTH-1:0]           shadow_d [NUM_SLOTS];
    logic [NUM_SLOTS*WIDTH-1:0] ch_q, ch_d;
    logic                       fv_q, fv_d;
    logic                       err_q, err_d;

    logic  cnt_en, cnt_load, cnt_clr;
    slot_t slot;

    tdm_slot_counter u_slot_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (cnt_en),
        .load1_i (cnt_load),
        .clr_i   (cnt_clr),
        .slot_o  (slot)
    );

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        ch_d     = ch_q;
        fv_d     = 1'b0;
        err_d    = 1'b0;
        cnt_en   = 1'b0;
        cnt_load = 1'b0;
        cnt_clr  = 1'b0;

        if (!en_bar) begin
            case (state_q)
                IDLE: begin
                    if (sync) begin
                        shadow_d[0] = din;
                        cnt_load    = 1'b1;
                        state_d     = RUN;
                    end
                end
                RUN: begin
                    if (sync && slot != '0) begin
                        // Early sync: drop the partial frame and restart at slot 1.
                        err_d       = 1'b1;
                        shadow_d    = '{default: '0};
                        shadow_d[0] = din;
                        cnt_load    = 1'b1;
                    end else if (slot == '0 && !sync && SYNC_EVERY_FRAME) begin
                        err_d   = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = IDLE;
                    end else begin
                        shadow_d[slot] = din;
                        cnt_en         = 1'b1;
                        if (is_last_slot(slot)) begin
                            // Slot 7 bypasses the shadow so ch updates on this edge.
                            for (int unsigned k = 0; k < NUM_SLOTS - 1; k++) begin
                                ch_d[k*WIDTH +: WIDTH] = shadow_q[k];
                            end
                            ch_d[(NUM_SLOTS-1)*WIDTH +: WIDTH] = din;
                            fv_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '{default: '0};
            ch_q     <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            ch_q     <= ch_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
        end
    end

    assign s           = slot;
    assign ch          = ch_q;
    assign frame_valid = fv_q;
    assign sync_err    = err_q;
    assign locked      = (state_q == RUN);

endmodule
